// File: rtl/relu_mask_stack.sv
// LIFO of ReLU "input > 0" masks: pushed on the forward pass, popped in reverse to gate gradients.
// Optional RELU_MASK_ID_CHECK_EN stores fwd_id per entry and flags tag mismatches on pop (err_id).
module relu_mask_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          fwd_valid,
  output logic          fwd_ready,
  input  logic [31:0]   fwd_vec [WIDTH-1:0],
  input  logic [31:0]   fwd_id,
  input  logic          bwd_valid,
  output logic          bwd_ready,
  input  logic [31:0]   bwd_grad [WIDTH-1:0],
  input  logic [31:0]   bwd_id,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_vec [WIDTH-1:0],
  output logic [CW-1:0] count,
  output logic          err_underflow,
  output logic          err_id
);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mask_q [DEPTH];
  logic [WIDTH-1:0] mask_d [DEPTH];
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_vec_q [WIDTH-1:0];
  logic [31:0]      out_vec_d [WIDTH-1:0];
  logic             err_uf_q, err_uf_d;

  logic             push_fire, pop_fire;
  logic [WIDTH-1:0] fwd_mask, rd_mask;

  assign bwd_ready = (count_q != '0) && (!out_valid_q || out_ready);
  assign pop_fire  = bwd_valid && bwd_ready;
  // Pop wins over a simultaneous push; the push simply stalls a cycle.
  assign fwd_ready = (count_q != CW'(DEPTH)) && !pop_fire;
  assign push_fire = fwd_valid && fwd_ready;

  // Strictly positive encoding: sign clear and magnitude bits non-zero (+NaN counts as positive).
  always_comb begin
    fwd_mask = '0;
    for (int j = 0; j < WIDTH; j++) begin
      fwd_mask[j] = !fwd_vec[j][31] && (fwd_vec[j][30:0] != 31'h0);
    end
  end

  // Top of stack is the entry at count-1; matching count against i+1 avoids a subtractor.
  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) rd_mask = mask_q[i];
    end
  end

  always_comb begin
    count_d = count_q;
    if (pop_fire)       count_d = count_q - CW'(1);
    else if (push_fire) count_d = count_q + CW'(1);

    for (int i = 0; i < DEPTH; i++) begin
      mask_d[i] = mask_q[i];
      if (push_fire && (count_q == CW'(i))) mask_d[i] = fwd_mask;
    end

    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    if (pop_fire) begin
      out_valid_d = 1'b1;
      for (int j = 0; j < WIDTH; j++) begin
        out_vec_d[j] = rd_mask[j] ? bwd_grad[j] : 32'h0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    err_uf_d = err_uf_q | (bwd_valid && (count_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      for (int j = 0; j < WIDTH; j++) out_vec_q[j] <= 32'h0;
      err_uf_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
      err_uf_q    <= err_uf_d;
    end
  end

  // Entries above count are dead, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    mask_q <= mask_d;
  end

`ifdef RELU_MASK_ID_CHECK_EN
  logic [31:0] id_q [DEPTH];
  logic [31:0] id_d [DEPTH];
  logic [31:0] rd_id;
  logic        err_id_q, err_id_d;

  always_comb begin
    rd_id = '0;
    for (int i = 0; i < DEPTH; i++) begin
      id_d[i] = id_q[i];
      if (push_fire && (count_q == CW'(i))) id_d[i] = fwd_id;
      if (count_q == CW'(i + 1)) rd_id = id_q[i];
    end
    err_id_d = err_id_q | (pop_fire && (rd_id != bwd_id));
  end

  always_ff @(posedge clk) begin
    id_q <= id_d;
    if (reset || clear) err_id_q <= 1'b0;
    else                err_id_q <= err_id_d;
  end

  assign err_id = err_id_q;
`else
  logic unused_ids;
  assign unused_ids = ^{fwd_id, bwd_id};
  assign err_id     = 1'b0;
`endif

  assign count         = count_q;
  assign out_valid     = out_valid_q;
  assign out_vec       = out_vec_q;
  assign err_underflow = err_uf_q;

endmodule

// File: tb/tb_relu_mask_stack.sv
// Bench for relu_mask_stack: directed scenarios plus random traffic against a queue-based model.
module tb_relu_mask_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = 32 * WIDTH;

  logic          clk = 1'b0;
  logic          reset, clear;
  logic          fwd_valid, fwd_ready;
  logic [31:0]   fwd_vec [WIDTH-1:0];
  logic [31:0]   fwd_id;
  logic          bwd_valid, bwd_ready;
  logic [31:0]   bwd_grad [WIDTH-1:0];
  logic [31:0]   bwd_id;
  logic          out_valid, out_ready;
  logic [31:0]   out_vec [WIDTH-1:0];
  logic [CW-1:0] count;
  logic          err_underflow, err_id;

  relu_mask_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .fwd_valid     (fwd_valid),
    .fwd_ready     (fwd_ready),
    .fwd_vec       (fwd_vec),
    .fwd_id        (fwd_id),
    .bwd_valid     (bwd_valid),
    .bwd_ready     (bwd_ready),
    .bwd_grad      (bwd_grad),
    .bwd_id        (bwd_id),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_vec       (out_vec),
    .count         (count),
    .err_underflow (err_underflow),
    .err_id        (err_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a stack of whole forward vectors; gating is decided at pop time.
  typedef struct {
    logic [PW-1:0] vec;
    logic [31:0]   id;
  } ent_t;

  ent_t          stk[$];
  bit            m_ov, m_uf, m_eid;
  logic [PW-1:0] m_vec;

  function automatic logic [PW-1:0] pack(input logic [31:0] a [WIDTH-1:0]);
    logic [PW-1:0] p;
    for (int j = 0; j < WIDTH; j++) p[32*j +: 32] = a[j];
    return p;
  endfunction

  function automatic bit is_pos(input logic [31:0] f);
    return (f[31] == 1'b0) && (f[30:0] != 31'h0);
  endfunction

  // Inputs are already driven (posedge+1); check at posedge+3, then advance one clock.
  task automatic step();
    int   sz;
    bit   pop, push, erdy_b, erdy_f;
    ent_t e;
    #2;
    sz     = stk.size();
    erdy_b = (sz != 0) && (!m_ov || out_ready);
    pop    = bwd_valid && erdy_b;
    erdy_f = (sz != DEPTH) && !pop;
    push   = fwd_valid && erdy_f;
    check("count", PW'(count), PW'(sz));
    check("fwd_ready", PW'(fwd_ready), PW'(erdy_f));
    check("bwd_ready", PW'(bwd_ready), PW'(erdy_b));
    check("out_valid", PW'(out_valid), PW'(m_ov));
    if (m_ov) check("out_vec", pack(out_vec), m_vec);
    check("err_underflow", PW'(err_underflow), PW'(m_uf));
    check("err_id", PW'(err_id), PW'(m_eid));
    if (reset || clear) begin
      stk.delete();
      m_ov  = 1'b0;
      m_uf  = 1'b0;
      m_eid = 1'b0;
      m_vec = '0;
    end else begin
      if (bwd_valid && sz == 0) m_uf = 1'b1;
      if (pop) begin
        e = stk.pop_back();
        for (int j = 0; j < WIDTH; j++)
          m_vec[32*j +: 32] = is_pos(e.vec[32*j +: 32]) ? bwd_grad[j] : 32'h0;
        m_ov = 1'b1;
`ifdef RELU_MASK_ID_CHECK_EN
        if (e.id != bwd_id) m_eid = 1'b1;
`endif
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (push) begin
        e.vec = pack(fwd_vec);
        e.id  = fwd_id;
        stk.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fv, input bit bv, input bit ordy);
    fwd_valid = fv;
    bwd_valid = bv;
    out_ready = ordy;
    step();
  endtask

  function automatic logic [31:0] rnd_elem();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FC0_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic rnd_fwd();
    for (int j = 0; j < WIDTH; j++) fwd_vec[j] = rnd_elem();
  endtask

  task automatic rnd_grad();
    for (int j = 0; j < WIDTH; j++) bwd_grad[j] = $urandom();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    clear = 1'b0;
  endtask

  logic [31:0] t1_in  [WIDTH-1:0];
  logic [31:0] t1_exp [WIDTH-1:0];
  int          trace [6];

  initial begin
    reset = 1'b1; clear = 1'b0; fwd_valid = 1'b0; bwd_valid = 1'b0; out_ready = 1'b1;
    fwd_id = '0; bwd_id = '0;
    for (int j = 0; j < WIDTH; j++) begin
      fwd_vec[j]  = '0;
      bwd_grad[j] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    stk.delete(); m_ov = 0; m_uf = 0; m_eid = 0; m_vec = '0;

    // Mask rule on special encodings, one-cycle output latency.
    t1_in  = '{32'h0000_0001, 32'h7F80_0000, 32'hC040_0000, 32'h4020_0000,
               32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'h3F80_0000};
    t1_exp = '{32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h3F80_0000,
               32'h0, 32'h0, 32'h0, 32'h3F80_0000};
    fwd_vec = t1_in;
    for (int j = 0; j < WIDTH; j++) bwd_grad[j] = 32'h3F80_0000;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    #2;
    check("t1_latency", PW'(out_valid), PW'(1));
    check("t1_out_vec", pack(out_vec), pack(t1_exp));
    drive(1'b0, 1'b0, 1'b1);

    // LIFO order with count trace.
    do_clear();
    trace = '{1, 2, 3, 2, 1, 0};
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        rnd_fwd();
        drive(1'b1, 1'b0, 1'b1);
      end else begin
        rnd_grad();
        drive(1'b0, 1'b1, 1'b1);
      end
      #2;
      check("lifo_trace", PW'(count), PW'(trace[k]));
    end

    // Full stack holds the 17th push; underflow is sticky until clear.
    do_clear();
    for (int k = 0; k < DEPTH + 1; k++) begin
      rnd_fwd();
      drive(1'b1, 1'b0, 1'b1);
    end
    #2;
    check("full_count", PW'(count), PW'(DEPTH));
    check("full_fwd_ready", PW'(fwd_ready), PW'(0));
    do_clear();
    drive(1'b0, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    #2;
    check("uf_sticky", PW'(err_underflow), PW'(1));
    do_clear();
    #2;
    check("uf_cleared", PW'(err_underflow), PW'(0));

    // Output stall for 5 cycles, then back-to-back pops keep out_valid high.
    do_clear();
    repeat (3) begin
      rnd_fwd();
      drive(1'b1, 1'b0, 1'b1);
    end
    rnd_grad();
    drive(1'b0, 1'b1, 1'b0);
    repeat (5) begin
      rnd_grad();
      drive(1'b0, 1'b1, 1'b0);
    end
    repeat (2) begin
      rnd_grad();
      drive(1'b0, 1'b1, 1'b1);
      #2;
      check("b2b_valid", PW'(out_valid), PW'(1));
    end

    // Simultaneous push and pop at count 2, then reset with a pending output.
    do_clear();
    repeat (2) begin
      rnd_fwd();
      drive(1'b1, 1'b0, 1'b1);
    end
    rnd_fwd();
    rnd_grad();
    drive(1'b1, 1'b1, 1'b1);
    #2;
    check("pop_wins_count", PW'(count), PW'(1));
    drive(1'b1, 1'b0, 1'b0);
    #2;
    check("push_next_count", PW'(count), PW'(2));
    drive(1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    check("rst_out_valid", PW'(out_valid), PW'(0));
    check("rst_count", PW'(count), PW'(0));

    // Tag mismatch: output still produced; err_id only with the id check built in.
    do_clear();
    fwd_id = 32'd5;
    rnd_fwd();
    drive(1'b1, 1'b0, 1'b1);
    bwd_id = 32'd6;
    rnd_grad();
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    #2;
`ifdef RELU_MASK_ID_CHECK_EN
    check("id_mismatch", PW'(err_id), PW'(1));
`else
    check("id_ignored", PW'(err_id), PW'(0));
`endif

    // Random traffic.
    do_clear();
    for (int c = 0; c < 3000; c++) begin
      rnd_fwd();
      rnd_grad();
      fwd_id = 32'($urandom_range(0, 3));
      bwd_id = 32'($urandom_range(0, 3));
      clear  = ($urandom_range(0, 199) == 0);
      reset  = ($urandom_range(0, 399) == 0);
      drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 70));
    end
    clear = 1'b0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
